alu_display: RTL
================

Name: alu_display

Overview:
- Downstream stage of the 4-bit ALU.
- Captures A, B, S and the 8-bit result Y on a load strobe and time-multiplexes them onto a 4-digit common-anode seven-segment display.
- Digit mapping: digit3 = A, digit2 = B, digit1 = Y[7:4], digit0 = Y[3:0].
- The decimal point marks the selected operation.
- All outputs are registered.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit is shown. Legal range is 1 and above. Counter width is $clog2(REFRESH_DIV), minimum 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active low
- A  input  4  ALU operand A
- B  input  4  ALU operand B
- S  input  2  ALU operation select
- Y  input  8  ALU result
- load  input  1  capture strobe; samples A/B/S/Y on any rising clk edge where load=1
- an  output  4  digit anodes, active low, one-hot-low when active
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active low
- dp  output  1  decimal point, active low

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).

Reset (rst_n=0 at a clk edge):
- Held regs A_h, B_h, Y_h and S_h all clear to 0.
- Refresh counter cnt = 0, digit index idx = 0.
- Outputs: an=4'b1111, seg=7'b1111111, dp=1 (display dark).
- load is ignored while rst_n=0.
- Reset asserted mid-scan takes effect on that same edge, with no partial state kept.

Capture:
- load=1 at an edge with rst_n=1: A_h<=A, B_h<=B, S_h<=S, Y_h<=Y.
- load may be held high; capture repeats every cycle (last value wins).
- Capture does not disturb cnt or idx.

Scan:
- cnt increments each cycle while rst_n=1.
- When cnt==REFRESH_DIV-1: cnt<=0 and idx<=idx+1 (mod 4, 3 wraps to 0).
- REFRESH_DIV=1: idx advances every cycle.

Output register, every cycle with rst_n=1:
- an <= ~(4'b0001<<idx).
- seg <= hex7(digit(idx)), where digit(0)=Y_h[3:0], digit(1)=Y_h[7:4], digit(2)=B_h, digit(3)=A_h.
- dp <= (idx==S_h) ? 0 : 1, i.e. dp is lit on digit number S_h.

Latency:
- Output reflects idx/held regs one cycle later.
- A load at edge N appears on seg at edge N+1 if that digit is currently selected.
- First cycle after reset release: an=4'b1110, showing digit0 = 0.

Simultaneous load and idx advance: both take effect; the output at the next edge uses the new idx and the new held values.

hex7 table (active low, gfedcba):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110

Decomposition:
- Package alu_disp_pkg holds:
  - digit-index typedef (2-bit);
  - active-low constants AN_OFF=4'b1111 and SEG_BLANK=7'b1111111;
  - the 16-entry hex-to-segment constant table.
- One natural sub-module: hex_to_7seg, a combinational 4-bit to 7-bit decoder used on the muxed nibble.
- Counter, capture registers and output registers stay in alu_display.

Test Plan (REFRESH_DIV=4 in simulation):
- Reset held 3 cycles, then released → an=1111/seg=1111111/dp=1 during reset; the first edge after release gives an=1110, seg=1000000, dp=0 (S_h=0 so digit0 dp lit).
- Load A=3, B=5, S=0, Y=8'h08, then run 16 cycles → the sequence an=1110 seg=0000000 (8), an=1101 seg=1000000 (0), an=1011 seg=0010010 (5), an=0111 seg=0110000 (3), each held 4 cycles; idx wraps back to 0.
- Load S=2'b11 with Y=8'hAF → dp=0 only while an=0111; digit0 shows F (0001110) and digit1 shows A (0001000).
- Load pulse timed on the edge where idx advances 0→1, new Y=8'h90 → the next output is an=1101 with seg=0010000 (9); there is no glitch frame with old data.
- load held high for 5 cycles while Y ramps 1..5 → the held value is 5; scan timing is unchanged versus the no-load case.
- Reset asserted while idx=2 mid-count → the next edge shows a dark display, held regs are 0, and after release scanning restarts at idx=0, cnt=0.

Source files
------------

// File: rtl/alu_disp_pkg.sv
// -----------------------------------------------------------------------------
// alu_disp_pkg
// Shared types and constants for the ALU seven-segment display stage:
//   - digit_idx_t : 2-bit index of the currently scanned digit (0..3)
//   - AN_OFF      : all anodes off (active low)
//   - SEG_BLANK   : all cathodes off (active low)
//   - HEX7_TABLE  : 16-entry hex-to-segment table, active low, bit order gfedcba
// Helper functions:
//   - hex7()          : nibble to segment pattern lookup
//   - an_onehot_low() : digit index to one-hot-low anode pattern
// -----------------------------------------------------------------------------
package alu_disp_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [3:0] AN_OFF    = 4'b1111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Entry 15 is the leftmost element so that HEX7_TABLE[n] yields glyph n.
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] hex7(input logic [3:0] nibble);
        return HEX7_TABLE[nibble];
    endfunction

    function automatic logic [3:0] an_onehot_low(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// -----------------------------------------------------------------------------
// hex_to_7seg
// Combinational 4-bit to seven-segment decoder (active low, gfedcba).
// Ports:
//   nibble_i : hex digit to display
//   seg_o    : cathode pattern, active low
// -----------------------------------------------------------------------------
module hex_to_7seg
    import alu_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Table lookup; every nibble value has a defined glyph.
    always_comb begin
        seg_o = hex7(nibble_i);
    end

endmodule

// File: rtl/alu_display.sv
// -----------------------------------------------------------------------------
// alu_display
// Captures the ALU operands, select and result on a load strobe and scans
// them onto a 4-digit common-anode seven-segment display:
//   digit3 = A, digit2 = B, digit1 = Y[7:4], digit0 = Y[3:0].
// The decimal point is lit on the digit whose number equals the held select.
// Parameters:
//   REFRESH_DIV : clock cycles each digit stays selected (>= 1)
// Ports:
//   clk   : system clock
//   rst_n : synchronous reset, active low
//   A, B  : ALU operands (4 bits)
//   S     : ALU operation select (2 bits)
//   Y     : ALU result (8 bits)
//   load  : capture strobe, samples A/B/S/Y on every edge where it is high
//   an    : digit anodes, active low, one-hot-low
//   seg   : cathodes {g,f,e,d,c,b,a}, active low
//   dp    : decimal point, active low
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module alu_display
    import alu_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [1:0] S,
    input  logic [7:0] Y,
    input  logic       load,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    // REFRESH_DIV == 1 still needs a 1-bit counter; it simply stays at 0.
    localparam int             CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [3:0]       a_q,   a_d;
    logic [3:0]       b_q,   b_d;
    logic [1:0]       s_q,   s_d;
    logic [7:0]       y_q,   y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       idx_q, idx_d;
    logic [3:0]       an_q,  an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q,  dp_d;

    logic [3:0]       nibble_s;
    logic [6:0]       seg_s;

    // Select the nibble belonging to the currently scanned digit.
    always_comb begin
        nibble_s = 4'h0;
        case (idx_q)
            2'd0:    nibble_s = y_q[3:0];
            2'd1:    nibble_s = y_q[7:4];
            2'd2:    nibble_s = b_q;
            2'd3:    nibble_s = a_q;
            default: nibble_s = 4'h0;
        endcase
    end

    hex_to_7seg u_hex_to_7seg (
        .nibble_i (nibble_s),
        .seg_o    (seg_s)
    );

    // Next-state: capture, refresh counter / digit index, and output frame.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        s_d   = s_q;
        y_d   = y_q;
        cnt_d = cnt_q;
        idx_d = idx_q;

        if (load) begin
            a_d = A;
            b_d = B;
            s_d = S;
            y_d = Y;
        end else begin
            a_d = a_q;
            b_d = b_q;
            s_d = s_q;
            y_d = y_q;
        end

        // idx wraps 3 -> 0 through natural 2-bit overflow.
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end

        // The frame is built from the current idx and held values, so any
        // load or idx step taken on this edge shows up one edge later.
        an_d  = an_onehot_low(idx_q);
        seg_d = seg_s;
        if (idx_q == s_q) begin
            dp_d = 1'b0;
        end else begin
            dp_d = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= 4'h0;
            b_q   <= 4'h0;
            s_q   <= 2'd0;
            y_q   <= 8'h00;
            cnt_q <= '0;
            idx_q <= 2'd0;
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            y_q   <= y_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
